gate_input_conditioner: RTL and testbench
=========================================

Name: gate_input_conditioner

Overview:
- Upstream front end for the two-input gate block.
- Turns two raw, bouncing board buttons or switches into clean, synchronous operands `a` and `b`.
- Per channel: 2-FF synchronizer, counter-based debouncer, rising-edge detector and optional toggle latch.
- Outputs `a` and `b` wire directly to the gate block's `a`/`b` inputs; the press pulses are available for LEDs or counters.

Parameters:
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles needed to accept a new level (1 ms at 100 MHz); legal range ≥ 2.
- TOGGLE_MODE, 1, 1 = each debounced press toggles the operand; 0 = operand follows the debounced level.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_a_raw  in  1  raw asynchronous button/switch for operand a.
- btn_b_raw  in  1  raw asynchronous button/switch for operand b.
- a  out  1  conditioned operand a, feeds gate input a.
- b  out  1  conditioned operand b, feeds gate input b.
- a_press  out  1  one-cycle pulse on debounced 0->1 of channel a.
- b_press  out  1  one-cycle pulse on debounced 0->1 of channel b.

Behaviour:
- Interface: one clock (`clk`); reset `rst_n` is asynchronous, active-low. All flops clear immediately on `rst_n` = 0. Release is sampled on `clk` rising edge.
- Reset values: sync FFs 0, stable 0, counter 0, state IDLE, `a`/`b` 0, `a_press`/`b_press` 0.
- Channels a and b are fully independent; simultaneous activity on both is legal and never interacts.
- Synchronizer: `raw` -> s1 -> s2, one flop each. s2 is the only signal the debouncer sees.
- Debounce FSM per channel, states IDLE and COUNT:
  - IDLE: s2 == stable, counter held at 0. If s2 != stable, go to COUNT with counter = 1.
  - COUNT, s2 == stable (bounce back): go to IDLE, counter = 0; stable unchanged.
  - COUNT, s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter = 0, go to IDLE.
  - COUNT otherwise: counter + 1.
  - The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Latency: a clean `raw` edge changes stable 2 + DEBOUNCE_CYCLES clock edges after the first edge that samples the new level.
- Any bounce shorter than DEBOUNCE_CYCLES cycles (measured at s2) is rejected entirely.
- Press pulse: `x_press` = stable & ~stable_d, registered. It is high for exactly one cycle, on the cycle after stable rises. No pulse on release.
- Operand output:
  - TOGGLE_MODE = 1: `x` <= ~`x` in the same cycle `x_press` is high.
  - TOGGLE_MODE = 0: `x` = stable_d, aligning it with the pulse timing.
- Reset mid-count: counter and state clear and the pending level is discarded. After release, a still-asserted raw input is re-debounced from zero.
- Reset while `raw` is held high: no press pulse until the full debounce completes after release.
- All outputs are registered; no combinational path from raw inputs to outputs.

Decomposition:
- Package gate_in_pkg:
  - typedef enum {IDLE, COUNT} deb_state_t.
  - Constant DEF_DEBOUNCE_CYCLES = 100000.
  - Constant SIM_DEBOUNCE_CYCLES = 8.
- Sub-module debounce_ch: one channel comprising synchronizer, FSM/counter, edge detect and toggle/level output.
  - Parameters: DEBOUNCE_CYCLES, TOGGLE_MODE.
  - Ports: clk, rst_n, raw, level_out, press.
- Top gate_input_conditioner instantiates debounce_ch twice, for a and b.

Test Plan (DEBOUNCE_CYCLES = 8, TOGGLE_MODE = 1 unless noted):
- Clean press: hold `btn_a_raw` = 1 for 20 cycles -> `a_press` high for exactly 1 cycle, at edge 2+8+1 = 11 after the first sampling edge; `a` goes 0->1 the same cycle; `b` stays 0.
- Bounce rejection: `btn_a_raw` toggles 1/0 with a 3-cycle high / 2-cycle low pattern 5 times, then stays 0 -> no `a_press`, `a` = 0; state returns to IDLE after each high period.
- Toggle sequence: three clean presses on b, each held 20 cycles and released 20 cycles -> three `b_press` pulses, `b` sequence 1,0,1; no pulses on releases.
- Level mode (TOGGLE_MODE = 0): hold `btn_a_raw` high 20 cycles, then low -> `a` rises 11 cycles after the press edge, falls 11 cycles after the release edge; one `a_press` only.
- Simultaneous channels: both raw inputs rise on the same edge -> `a_press` and `b_press` assert on the same cycle; `a` = `b` = 1.
- Reset mid-count: raise `btn_a_raw`, assert `rst_n` = 0 at cycle 6 for 3 cycles, keep raw high -> outputs 0 immediately (asynchronous); after release, `a_press` fires 11 cycles after the first post-reset sampling edge.

Source files
------------

// File: rtl/gate_in_pkg.sv
// Shared types and constants for the gate input conditioner.
package gate_in_pkg;

  // Debouncer states: IDLE while the synchronized input matches the accepted
  // level, COUNT while a differing level is being timed.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_t;

  // 1 ms at 100 MHz.
  localparam int DEF_DEBOUNCE_CYCLES = 100000;

  // Short debounce period so simulations stay fast.
  localparam int SIM_DEBOUNCE_CYCLES = 8;

endpackage : gate_in_pkg

// File: rtl/debounce_ch.sv
// One conditioning channel: 2-FF synchronizer, counter-based debouncer,
// rising-edge press pulse and a toggle or level operand output.
module debounce_ch
  import gate_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit TOGGLE_MODE     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level_out,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_s1_reg;
  logic             sync_s2_reg;
  deb_state_t       state_reg;
  deb_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             stable_reg;
  logic             stable_next;
  logic             stable_d_reg;
  logic             press_reg;
  logic             level_reg;

  // Two-flop synchronizer; only sync_s2_reg is seen by the debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1_reg <= 1'b0;
      sync_s2_reg <= 1'b0;
    end else begin
      sync_s1_reg <= raw;
      sync_s2_reg <= sync_s1_reg;
    end
  end

  // Debouncer state, counter and accepted level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  // Next-state logic: a new level is accepted only after it has been seen
  // for DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level
  // abandons the count. The counter saturates at CNT_LAST by construction.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (sync_s2_reg != stable_reg) begin
          state_next = COUNT;
          cnt_next   = CNT_ONE;
        end
      end
      COUNT: begin
        if (sync_s2_reg == stable_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = IDLE;
          cnt_next    = '0;
          stable_next = sync_s2_reg;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered press pulse and operand; the toggle flips on the same edge
  // the pulse rises, and level mode tracks the delayed accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d_reg <= 1'b0;
      press_reg    <= 1'b0;
      level_reg    <= 1'b0;
    end else begin
      stable_d_reg <= stable_reg;
      press_reg    <= stable_reg & ~stable_d_reg;
      if (TOGGLE_MODE) begin
        level_reg <= level_reg ^ (stable_reg & ~stable_d_reg);
      end else begin
        level_reg <= stable_reg;
      end
    end
  end

  assign level_out = level_reg;
  assign press     = press_reg;

endmodule : debounce_ch

// File: rtl/gate_input_conditioner.sv
// Conditions two raw board buttons into clean synchronous operands a and b
// for the gate block, plus one-cycle press pulses per channel.
module gate_input_conditioner
  import gate_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit TOGGLE_MODE     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_press,
  output logic b_press
);

  logic [1:0] raw_vec;
  logic [1:0] level_vec;
  logic [1:0] press_vec;

  assign raw_vec = {btn_b_raw, btn_a_raw};

  // Two fully independent channels: index 0 is operand a, index 1 is b.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .TOGGLE_MODE    (TOGGLE_MODE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw_vec[gi]),
      .level_out(level_vec[gi]),
      .press    (press_vec[gi])
    );
  end

  assign a       = level_vec[0];
  assign b       = level_vec[1];
  assign a_press = press_vec[0];
  assign b_press = press_vec[1];

endmodule : gate_input_conditioner

// File: tb/tb_gate_input_conditioner.sv
// Directed bench for gate_input_conditioner with an 8-cycle debounce:
// one toggle-mode instance and one level-mode instance.
module tb_gate_input_conditioner;
  import gate_in_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_a_raw = 1'b0, btn_b_raw = 1'b0;
  logic a, b, a_press, b_press;
  logic lvl_a_raw = 1'b0, lvl_b_raw = 1'b0;
  logic lvl_a, lvl_b, lvl_a_press, lvl_b_press;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int na = 0, nb = 0, nla = 0;

  always #5 clk = ~clk;

  gate_input_conditioner #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
    .TOGGLE_MODE    (1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_a_raw(btn_a_raw), .btn_b_raw(btn_b_raw),
    .a(a), .b(b), .a_press(a_press), .b_press(b_press)
  );

  gate_input_conditioner #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
    .TOGGLE_MODE    (1'b0)
  ) dut_lvl (
    .clk(clk), .rst_n(rst_n), .btn_a_raw(lvl_a_raw), .btn_b_raw(lvl_b_raw),
    .a(lvl_a), .b(lvl_b), .a_press(lvl_a_press), .b_press(lvl_b_press)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, tallying press pulses seen on each channel.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      na  += int'(a_press);
      nb  += int'(b_press);
      nla += int'(lvl_a_press);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    na = 0; nb = 0; nla = 0;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_a_press", a_press, 0);
    chk("rst_b_press", b_press, 0);
    do_reset();

    // Clean press on a: pulse at edge 11 after the first sampling edge
    btn_a_raw = 1'b1;
    run(10);
    chk("clean_press_e10", a_press, 0);
    chk("clean_a_e10", a, 0);
    run(1);
    chk("clean_press_e11", a_press, 1);
    chk("clean_a_e11", a, 1);
    chk("clean_b_e11", b, 0);
    run(1);
    chk("clean_press_e12", a_press, 0);
    run(8);
    btn_a_raw = 1'b0;
    run(20);
    chk("clean_press_count", na, 1);
    chk("clean_a_after_release", a, 1);
    chk("clean_b_press_count", nb, 0);

    // Bounce rejection: 3 high / 2 low, five times
    do_reset();
    chk("bounce_a_after_reset", a, 0);
    for (int k = 0; k < 5; k++) begin
      btn_a_raw = 1'b1;
      run(3);
      btn_a_raw = 1'b0;
      run(2);
    end
    run(20);
    chk("bounce_press_count", na, 0);
    chk("bounce_a", a, 0);

    // Toggle sequence on b: 1, 0, 1
    do_reset();
    for (int k = 0; k < 3; k++) begin
      btn_b_raw = 1'b1;
      run(20);
      chk($sformatf("toggle_b_press%0d", k), nb, k + 1);
      chk($sformatf("toggle_b_val%0d", k), b, (k % 2 == 0) ? 1 : 0);
      btn_b_raw = 1'b0;
      run(20);
      chk($sformatf("toggle_b_release%0d", k), nb, k + 1);
    end
    chk("toggle_a_idle", a, 0);

    // Level mode on the second instance
    do_reset();
    lvl_a_raw = 1'b1;
    run(10);
    chk("level_a_e10", lvl_a, 0);
    run(1);
    chk("level_a_e11", lvl_a, 1);
    chk("level_press_e11", lvl_a_press, 1);
    run(9);
    lvl_a_raw = 1'b0;
    run(10);
    chk("level_a_rel_e10", lvl_a, 1);
    run(1);
    chk("level_a_rel_e11", lvl_a, 0);
    chk("level_press_rel_e11", lvl_a_press, 0);
    run(20);
    chk("level_press_count", nla, 1);

    // Simultaneous channels
    do_reset();
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    run(10);
    chk("simul_a_press_e10", a_press, 0);
    chk("simul_b_press_e10", b_press, 0);
    run(1);
    chk("simul_a_press_e11", a_press, 1);
    chk("simul_b_press_e11", b_press, 1);
    chk("simul_a", a, 1);
    chk("simul_b", b, 1);

    // Asynchronous reset clears outputs between clock edges
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", a, 0);
    chk("async_rst_b", b, 0);
    chk("async_rst_a_press", a_press, 0);
    chk("async_rst_b_press", b_press, 0);
    btn_b_raw = 1'b0;
    btn_a_raw = 1'b0;
    do_reset();

    // Reset mid-count with raw held high: re-debounce from zero
    btn_a_raw = 1'b1;
    run(5);
    rst_n = 1'b0;
    run(3);
    chk("midrst_a", a, 0);
    rst_n = 1'b1;
    na = 0;
    run(10);
    chk("midrst_press_e10", a_press, 0);
    chk("midrst_a_e10", a, 0);
    run(1);
    chk("midrst_press_e11", a_press, 1);
    chk("midrst_a_e11", a, 1);
    run(5);
    chk("midrst_press_count", na, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_gate_input_conditioner
